// File: rtl/game_pkg.sv
// Shared types for the guess game: value width, tries width and FSM state encoding.
package game_pkg;

    localparam int VAL_W = 4;
    localparam int TRY_W = 3;

    typedef logic [VAL_W-1:0] val_t;
    typedef logic [TRY_W-1:0] tries_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    // Secrets above the legal range are pinned to the top legal value.
    function automatic val_t clamp_val(input val_t v, input val_t limit);
        return (v > limit) ? limit : v;
    endfunction

endpackage

// File: rtl/guess_game_ctrl.sv
// Number-guessing round controller: captures a secret on start, grades guesses
// with a one-cycle registered result, and tracks tries up to a win or loss.
module guess_game_ctrl
    import game_pkg::*;
#(
    parameter int MAX_TRIES = 4,
    parameter int MAX_VALUE = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] random_number,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [VAL_W-1:0] guess,
    output logic             guess_ready,
    output logic             result_valid,
    output logic             hint_hi,
    output logic             hint_lo,
    output logic             bad_guess,
    output logic             win,
    output logic             lose,
    output logic [TRY_W-1:0] tries,
    output logic [VAL_W-1:0] reveal
);

    localparam val_t   MAX_V = val_t'(MAX_VALUE);
    localparam tries_t MAX_T = tries_t'(MAX_TRIES);

    state_t state, state_n;
    val_t   secret, secret_n;
    tries_t tries_q, tries_n;
    logic   rv_n, hi_n, lo_n, bad_n;
    logic   accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            secret       <= '0;
            tries_q      <= '0;
            result_valid <= 1'b0;
            hint_hi      <= 1'b0;
            hint_lo      <= 1'b0;
            bad_guess    <= 1'b0;
        end else begin
            state        <= state_n;
            secret       <= secret_n;
            tries_q      <= tries_n;
            result_valid <= rv_n;
            hint_hi      <= hi_n;
            hint_lo      <= lo_n;
            bad_guess    <= bad_n;
        end
    end

    assign accept = (state == PLAY) && guess_valid;

    always_comb begin
        state_n  = state;
        secret_n = secret;
        tries_n  = tries_q;
        rv_n     = 1'b0;
        hi_n     = 1'b0;
        lo_n     = 1'b0;
        bad_n    = 1'b0;

        // start outranks a coinciding guess, which is dropped without a result
        if (start) begin
            state_n  = PLAY;
            secret_n = clamp_val(random_number, MAX_V);
            tries_n  = '0;
        end else if (accept) begin
            rv_n = 1'b1;
            if (guess > MAX_V) begin
                bad_n = 1'b1;
            end else begin
                tries_n = (tries_q < MAX_T) ? tries_t'(tries_q + 1'b1) : MAX_T;
                if (guess == secret) begin
                    state_n = WIN;
                end else begin
                    hi_n = (secret > guess);
                    lo_n = (secret < guess);
                    if (tries_n == MAX_T) begin
                        state_n = LOSE;
                    end
                end
            end
        end
    end

    assign guess_ready = (state == PLAY);
    assign win         = (state == WIN);
    assign lose        = (state == LOSE);
    assign tries       = tries_q;
    assign reveal      = (win || lose) ? secret : '0;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: directed rounds plus randomized play.
module tb_guess_game_ctrl;
    import game_pkg::*;

    localparam int MAX_TRIES = 4;
    localparam int MAX_VALUE = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [3:0] random_number = '0;
    logic [3:0] guess = '0;
    logic       guess_ready, result_valid, hint_hi, hint_lo, bad_guess, win, lose;
    logic [2:0] tries;
    logic [3:0] reveal;

    always #5 clk = ~clk;

    guess_game_ctrl #(.MAX_TRIES(MAX_TRIES), .MAX_VALUE(MAX_VALUE)) dut (
        .clk(clk), .reset(reset), .random_number(random_number), .start(start),
        .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
        .result_valid(result_valid), .hint_hi(hint_hi), .hint_lo(hint_lo),
        .bad_guess(bad_guess), .win(win), .lose(lose), .tries(tries), .reveal(reveal)
    );

    typedef struct {
        bit hi;
        bit lo;
        bit bad;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference round: secret, guess count, and whether the round is live/won/lost
    int m_secret = 0;
    int m_tries  = 0;
    bit m_play   = 0;
    bit m_won    = 0;
    bit m_lost   = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_secret = 0; m_tries = 0; m_play = 0; m_won = 0; m_lost = 0;
    endtask

    task automatic check_levels();
        check("guess_ready", guess_ready, m_play);
        check("win", win, m_won);
        check("lose", lose, m_lost);
        check("tries", tries, m_tries);
        check("reveal", reveal, (m_won || m_lost) ? m_secret : 0);
    endtask

    // Drive one cycle of stimulus; predict the result and the post-edge round state.
    task automatic step(input bit st, input int rn, input bit gv, input int g);
        res_t r;
        start = st;
        random_number = rn[3:0];
        guess_valid = gv;
        guess = g[3:0];
        if (st) begin
            m_secret = (rn > MAX_VALUE) ? MAX_VALUE : rn;
            m_tries = 0; m_play = 1; m_won = 0; m_lost = 0;
        end else if (gv && m_play) begin
            r.hi = 0; r.lo = 0; r.bad = 0;
            if (g > MAX_VALUE) begin
                r.bad = 1;
            end else begin
                m_tries++;
                if (g == m_secret) begin
                    m_play = 0; m_won = 1;
                end else begin
                    r.hi = (m_secret > g);
                    r.lo = (m_secret < g);
                    if (m_tries == MAX_TRIES) begin
                        m_play = 0; m_lost = 1;
                    end
                end
            end
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        guess_valid = 1'b0;
        check_levels();
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got result_valid=1 expected 0 at %0t", $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("hint_hi", hint_hi, e.hi);
                check("hint_lo", hint_lo, e.lo);
                check("bad_guess", bad_guess, e.bad);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_ready", guess_ready, 0);
        check("rst_result", result_valid, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        check("rst_tries", tries, 0);
        check("rst_reveal", reveal, 0);
        @(posedge clk);
        #3 reset = 1'b0;

        // guess in IDLE is ignored
        step(0, 0, 1, 5);

        // win: secret 7, guesses 3, 9, 7
        step(1, 7, 0, 0);
        step(0, 0, 1, 3);
        step(0, 0, 1, 9);
        step(0, 0, 1, 7);
        check("win_level", win, 1);
        check("win_tries", tries, 3);
        check("win_reveal", reveal, 7);
        // guess in WIN is ignored
        step(0, 0, 1, 7);
        check("win_hold_tries", tries, 3);

        // loss: secret 2, four high guesses
        step(1, 2, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 1, 6);
        step(0, 0, 1, 8);
        step(0, 0, 1, 9);
        check("lose_level", lose, 1);
        check("lose_tries", tries, 4);
        check("lose_reveal", reveal, 2);
        step(0, 0, 0, 0);

        // out-of-range guess, then clamped secret
        step(1, 4, 0, 0);
        step(0, 0, 1, 13);
        check("bad_tries", tries, 0);
        check("bad_ready", guess_ready, 1);
        step(1, 15, 0, 0);
        step(0, 0, 1, 10);
        check("clamp_reveal", reveal, 10);

        // start/guess collision
        step(1, 3, 0, 0);
        step(0, 0, 1, 1);
        step(1, 6, 1, 6);
        check("coll_tries", tries, 0);
        step(0, 0, 1, 6);
        check("coll_reveal", reveal, 6);

        // mid-round asynchronous reset
        step(1, 9, 0, 0);
        step(0, 0, 1, 2);
        step(0, 0, 1, 3);
        step(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("mrst_ready", guess_ready, 0);
        check("mrst_result", result_valid, 0);
        check("mrst_hi", hint_hi, 0);
        check("mrst_lo", hint_lo, 0);
        check("mrst_bad", bad_guess, 0);
        check("mrst_win", win, 0);
        check("mrst_lose", lose, 0);
        check("mrst_tries", tries, 0);
        check("mrst_reveal", reveal, 0);
        start = 1'b1; guess_valid = 1'b1; random_number = 4'd5; guess = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0; guess_valid = 1'b0;
        check_levels();
        #2 reset = 1'b0;
        step(1, 5, 0, 0);
        step(0, 0, 1, 4);
        step(0, 0, 1, 5);

        // randomized play
        for (int i = 0; i < 400; i++) begin
            bit st, gv;
            int rn, g;
            st = ($urandom_range(0, 15) == 0) || (!m_play && ($urandom_range(0, 2) == 0));
            rn = $urandom_range(0, 15);
            gv = ($urandom_range(0, 9) < 7);
            g  = ($urandom_range(0, 4) == 0) ? m_secret : $urandom_range(0, 15);
            step(st, rn, gv, g);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("pending_results", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
